// File: rtl/line_clear_if.sv
// Board-row access and pass-control signals between the line clear engine and the board owner.
interface line_clear_if #(
  parameter int COLS = 10
);
  logic            start;
  logic [4:0]      row_addr;
  logic [COLS-1:0] row_rdata;
  logic [COLS-1:0] row_wdata;
  logic            row_we;
  logic            busy;
  logic            done;
  logic [4:0]      lines_cleared;
  logic [15:0]     score;

  modport master (
    output start, row_rdata,
    input  row_addr, row_wdata, row_we, busy, done, lines_cleared, score
  );

  modport slave (
    input  start, row_rdata,
    output row_addr, row_wdata, row_we, busy, done, lines_cleared, score
  );
endinterface

// File: rtl/line_clear_engine.sv
// Removes full rows from the board in one read/compact pass and tops it up with empty rows.
// Define LINE_CLEAR_SCORE_EN to build the saturating score accumulator; otherwise score is tied to 0.
//
// state   | meaning
// IDLE    | waiting for start
// READ    | latch row rd into the buffer
// WRITE   | drop buffer if full, else copy it down to row wr
// FILL    | clear the rows vacated at the top
// DONE    | publish results, pulse done next cycle
module line_clear_engine #(
  parameter int ROWS = 23,
  parameter int COLS = 10
) (
  input  logic      clock_framerate,
  input  logic      resetn,
  line_clear_if.slave lc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      wr_q, wr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [COLS-1:0] buf_q, buf_d;
  logic [4:0]      lines_q, lines_d;
  logic            done_q, done_d;

  logic [4:0]      row_addr;
  logic [COLS-1:0] row_wdata;
  logic            row_we;

  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      lines_q <= lines_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    lines_d   = lines_q;
    done_d    = 1'b0;
    row_addr  = '0;
    row_wdata = '0;
    row_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lc.start) begin
          state_d = S_READ;
          rd_d    = '0;
          wr_d    = '0;
          cnt_d   = '0;
        end
      end

      S_READ: begin
        row_addr = rd_q;
        buf_d    = lc.row_rdata;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        row_addr = wr_q;
        if (&buf_q) begin
          cnt_d = cnt_q + 5'd1;
        end else begin
          // A surviving row that has not moved yet is already in place; skip the write.
          if (wr_q != rd_q) begin
            row_we    = 1'b1;
            row_wdata = buf_q;
          end
          wr_d = wr_q + 5'd1;
        end
        if (rd_q < 5'(ROWS - 1)) begin
          rd_d    = rd_q + 5'd1;
          state_d = S_READ;
        end else if (cnt_d != '0) begin
          state_d = S_FILL;
        end else begin
          state_d = S_DONE;
        end
      end

      S_FILL: begin
        row_addr = wr_q;
        row_we   = 1'b1;
        wr_d     = wr_q + 5'd1;
        if (wr_d == 5'(ROWS)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        lines_d = cnt_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [15:0] score_inc;
  logic [16:0] score_sum;

  always_comb begin
    score_inc = 16'd0;
    case (cnt_q)
      5'd0:    score_inc = 16'd0;
      5'd1:    score_inc = 16'd40;
      5'd2:    score_inc = 16'd100;
      5'd3:    score_inc = 16'd300;
      default: score_inc = 16'd1200;
    endcase
    score_sum = {1'b0, score_q} + {1'b0, score_inc};
    score_d   = score_q;
    if (state_q == S_DONE) begin
      score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign lc.score = score_q;
`else
  assign lc.score = '0;
`endif

  assign lc.row_addr      = row_addr;
  assign lc.row_wdata     = row_wdata;
  assign lc.row_we        = row_we;
  assign lc.busy          = (state_q != S_IDLE);
  assign lc.done          = done_q;
  assign lc.lines_cleared = lines_q;

endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 SHALL have parameter ROWS, default 23, number of board rows; row 0 is the bottom row.
REQ-002 SHALL have parameter COLS, default 10, cells per row.
REQ-003 SHALL have port clock_framerate  in  1  game frame clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request a clear pass, sampled only in IDLE.
REQ-006 SHALL have port row_addr  out  5  board row selected for read or write.
REQ-007 SHALL have port row_rdata  in  COLS  combinational read of board row row_addr, valid in the same cycle.
REQ-008 SHALL have port row_wdata  out  COLS  data written to row row_addr when row_we=1.
REQ-009 SHALL have port row_we  out  1  board row write strobe, committed at the clock edge.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port done  out  1  one-cycle pulse at pass end.
REQ-012 SHALL have port lines_cleared  out  5  full rows removed by the last completed pass.
REQ-013 SHALL have port score  out  16  accumulated score (see Configuration).

Function
REQ-014 SHALL implement states IDLE, READ, WRITE, FILL, DONE.
REQ-015 SHALL leave IDLE for READ on the edge that samples start=1, loading rd=0, wr=0, cnt=0.
REQ-016 In READ, SHALL drive row_addr=rd and latch row_rdata into an internal buffer, then go to WRITE.
REQ-017 In WRITE, if the buffer is all ones (full row), SHALL assert no write and increment cnt; otherwise SHALL write buffer to row wr and increment wr, with row_we=1 only when wr!=rd.
REQ-018 WRITE SHALL increment rd and return to READ while rd<ROWS-1; otherwise go to FILL if cnt>0, else DONE.
REQ-019 In FILL, SHALL write all-zero to row wr, incrementing wr, one row per cycle, until wr reaches ROWS, then go to DONE.
REQ-020 In DONE, SHALL pulse done=1, load lines_cleared<=cnt, update score, and return to IDLE next cycle.
REQ-021 Latency: done SHALL rise exactly 1+2*ROWS+cnt cycles after the edge that samples start (47+cnt with defaults).
REQ-022 start asserted while busy=1 SHALL be ignored and not queued.
REQ-023 Full rows SHALL be detected on any rows (non-contiguous, up to ROWS), with lines_cleared able to represent ROWS.
REQ-024 row_we SHALL be 0 in IDLE, READ and DONE; row_wdata SHALL be 0 when row_we=0.
REQ-025 Rows above the topmost surviving row SHALL read zero after the pass; surviving rows SHALL keep their relative order.

Reset
REQ-026 On resetn=0 at a clock edge, state SHALL become IDLE and busy, done, row_we, row_addr, lines_cleared, score SHALL be 0 by the next cycle.
REQ-027 Reset SHALL take priority over start and abort a pass mid-operation with no further writes; board contents are then undefined and the board owner SHALL reset the board as well.

Configuration
REQ-028 Macro LINE_CLEAR_SCORE_EN SHALL control scoring.
REQ-029 With LINE_CLEAR_SCORE_EN defined, DONE SHALL add 0/40/100/300/1200 for cnt=0/1/2/3/>=4, saturating at 65535.
REQ-030 Without LINE_CLEAR_SCORE_EN, score SHALL be constant 0 and no score register SHALL be synthesised.

Verification
REQ-031 Empty board, start pulse -> no row_we ever, done 47 cycles later, lines_cleared=0, score=0.
REQ-032 Row0=all ones, row1=10'b0000000001 -> row0=0000000001, rows1..22=0, lines_cleared=1, done at 48, score=40.
REQ-033 Rows 0-3 full, row4=10'b1000000000 -> row0=1000000000, rest 0, lines_cleared=4, score=1200.
REQ-034 Rows 2 and 5 full, rows 0,1,3,4,6 each distinct partial -> rows 0..4 hold old 0,1,3,4,6 in order, rows 5..22=0, lines_cleared=2.
REQ-035 start re-pulsed at cycle 10 of a pass -> single done only; resetn=0 at cycle 20 -> busy=0, row_we=0 next cycle, then a new start runs normally.
REQ-036 With LINE_CLEAR_SCORE_EN and score preset to 65000 via repeated passes, a 4-line clear -> score=65535.
